sevseg_mux2: RTL and testbench
==============================

Name: sevseg_mux2

Overview:
- Downstream display stage for the stopwatch.
- Consumes the stopwatch BCD outputs sec_tens, sec_ones and running, and drives a 2-digit common-anode multiplexed 7-segment display.
- Time-multiplexes the two digits from a refresh counter, decodes BCD to segments and snapshots inputs once per frame so the display never tears.
- Sits between the stopwatch core and the board pins.

Parameters:
- REFRESH_DIV, 50000: clock cycles per digit slot; must be >= 2.
- LZ_BLANK, 1: 1 blanks the tens digit when it is 0; 0 always shows it.
- BLINK_FRAMES, 32: frames per blink half-period; used only with SEVSEG_BLINK_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sec_ones  in  4  BCD ones digit from stopwatch
- sec_tens  in  4  BCD tens digit from stopwatch
- running  in  1  stopwatch run flag
- seg_n  out  7  active-low segments, bit order {g,f,e,d,c,b,a}
- an_n  out  2  active-low anode enables; [0]=ones, [1]=tens
- frame_tick  out  1  one-cycle pulse at each frame start (snapshot point)

Behaviour:
- Interface:
  - One clock, clk.
  - reset is synchronous and active-high, sampled on the rising edge of clk.
  - All outputs are registered.
- Reset values:
  - ref_cnt=0, digit state=DIG0.
  - Shadow ones/tens/running = 0/0/0.
  - seg_n=7'h7F, an_n=2'b11, frame_tick=0.
  - Blink phase=0.
- Refresh counter ref_cnt:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - Width is $clog2(REFRESH_DIV).
- Digit FSM, two states:
  - DIG0 (ones) and DIG1 (tens).
  - Toggles on every ref_cnt wrap: DIG0 -> DIG1 -> DIG0.
  - One full frame = 2*REFRESH_DIV cycles.
- Frame start is the cycle where ref_cnt==REFRESH_DIV-1 and state==DIG1. On that clock edge:
  - Shadow registers load sec_ones, sec_tens and running.
  - frame_tick is registered high for exactly one cycle.
  - Input changes at any other time are not visible until the next frame start.
- Output register load on every edge, from current (ref_cnt, state, shadow):
  - ref_cnt==0 is the dead-time slot: an_n=2'b11 and seg_n=7'h7F (anti-ghosting).
  - Otherwise an_n=2'b10 in DIG0 and 2'b01 in DIG1.
  - seg_n = decode(shadow digit for the current state).
  - Latency is exactly 1 cycle from the counter/state value to the pins.
- Decode, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Codes 10-15 (invalid BCD) show a dash: 7'h3F.
- Leading-zero blanking (LZ_BLANK=1): in DIG1 with shadow tens==0, an_n=2'b11 and seg_n=7'h7F. The ones digit is never blanked.
- Reset mid-frame: all state returns to the reset values on the next edge. No partial frame survives.
- Simultaneous input change at the frame-start edge: the values present at that edge are captured.

Optional Feature:
- Macro: SEVSEG_BLINK_EN.
- Defined:
  - A frame counter counts frame_tick pulses.
  - Blink phase toggles every BLINK_FRAMES frames.
  - When shadow running==0, shadow tens:ones != 00 and phase==1, an_n is forced to 2'b11 and seg_n to 7'h7F (paused display blinks).
  - Running, or a display of 00, shows steady.
  - Reset clears the counter and the phase.
- Not defined:
  - running only updates its shadow and has no effect on outputs.
  - No blink logic is synthesized.

Test Plan:
- Reset, REFRESH_DIV=4: hold reset 3 cycles -> seg_n=7F, an_n=11, frame_tick=0. After release, an_n sequence per 4-cycle slot is 11,10,10,10, then 11,11,11,11 (tens 0 is blanked).
- Snapshot, REFRESH_DIV=4:
  - Set tens=4, ones=7 mid-frame -> outputs unchanged until the frame_tick pulse.
  - Next frame shows an_n=10 with seg_n=78, then an_n=01 with seg_n=19.
- No tearing: change ones 7->5 one cycle after frame_tick -> the whole frame still shows 78; the following frame shows 12.
- Invalid and LZ_BLANK=0: tens=0xB, ones=9 -> seg_n=3F in the tens slot and 10 in the ones slot. With LZ_BLANK=0 and tens=0, the tens slot shows seg_n=40 with an_n=01.
- Reset mid-slot: assert reset at ref_cnt=2 in DIG1 -> next cycle an_n=11, shadow is 0, and the frame restarts at DIG0.
- With SEVSEG_BLINK_EN, BLINK_FRAMES=2, digits 12:
  - running=0 -> anodes are active for 2 frames, then all 11 for 2 frames, repeating.
  - running=1 -> steady display.

Source files
------------

// File: rtl/sevseg_mux2.sv
// Two-digit common-anode 7-segment multiplexer for the stopwatch BCD outputs.
// Inputs are snapshotted once per frame. Optional paused-display blink is enabled by SEVSEG_BLINK_EN.
module sevseg_mux2 #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned LZ_BLANK     = 1,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sec_ones,
  input  logic [3:0] sec_tens,
  input  logic       running,
  output logic [6:0] seg_n,
  output logic [1:0] an_n,
  output logic       frame_tick
);

  localparam int unsigned CW       = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_OFF   = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic {
    DIG0 = 1'b0,
    DIG1 = 1'b1
  } digit_t;

  digit_t          state;
  digit_t          state_d;
  logic [CW-1:0]   ref_cnt;
  logic [CW-1:0]   ref_d;
  logic [3:0]      sh_ones;
  logic [3:0]      sh_tens;
  logic            sh_run;
  logic            frame_start_c;
  logic            blink_c;
  logic [3:0]      digit_c;
  logic [6:0]      seg_d;
  logic [1:0]      an_d;

  // Active-low BCD decode, {g,f,e,d,c,b,a}; invalid codes show a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = SEG_DASH;
    endcase
  endfunction

  // State, refresh counter, shadow snapshot and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= DIG0;
      ref_cnt    <= '0;
      sh_ones    <= 4'd0;
      sh_tens    <= 4'd0;
      sh_run     <= 1'b0;
      seg_n      <= SEG_OFF;
      an_n       <= 2'b11;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_d;
      ref_cnt    <= ref_d;
      seg_n      <= seg_d;
      an_n       <= an_d;
      frame_tick <= frame_start_c;
      if (frame_start_c) begin
        sh_ones <= sec_ones;
        sh_tens <= sec_tens;
        sh_run  <= running;
      end
    end
  end

  // Next state and next pin values; ref_cnt==0 is the anti-ghosting dead slot.
  always_comb begin
    state_d       = state;
    ref_d         = ref_cnt + 1'b1;
    frame_start_c = 1'b0;
    seg_d         = SEG_OFF;
    an_d          = 2'b11;
    digit_c       = (state == DIG0) ? sh_ones : sh_tens;

    if (ref_cnt == REF_LAST) begin
      ref_d         = '0;
      state_d       = (state == DIG0) ? DIG1 : DIG0;
      frame_start_c = (state == DIG1);
    end

    if ((ref_cnt != '0) && !blink_c &&
        !((state == DIG1) && (LZ_BLANK != 0) && (sh_tens == 4'd0))) begin
      an_d  = (state == DIG0) ? 2'b10 : 2'b01;
      seg_d = decode(digit_c);
    end
  end

`ifdef SEVSEG_BLINK_EN
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] frm_cnt;
  logic          phase;

  // Frame counter paces the blink half-period.
  always_ff @(posedge clk) begin
    if (reset) begin
      frm_cnt <= '0;
      phase   <= 1'b0;
    end else if (frame_tick) begin
      if (frm_cnt == FRM_LAST) begin
        frm_cnt <= '0;
        phase   <= ~phase;
      end else begin
        frm_cnt <= frm_cnt + 1'b1;
      end
    end
  end

  assign blink_c = !sh_run && ((sh_tens != 4'd0) || (sh_ones != 4'd0)) && phase;
`else
  // Blink disabled: the run flag is only snapshotted.
  assign blink_c = 1'b0 & sh_run & (BLINK_FRAMES != 0);
`endif

endmodule

// File: tb/tb_sevseg_mux2.sv
// Directed self-checking bench for sevseg_mux2 with REFRESH_DIV=4.
// Runs a leading-zero-blanking instance and a no-blanking instance side by side.
module tb_sevseg_mux2;

`ifdef SEVSEG_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic       running;
  logic [6:0] seg_a, seg_b;
  logic [1:0] an_a, an_b;
  logic       ft_a, ft_b;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  always #5 clk = ~clk;

  sevseg_mux2 #(.REFRESH_DIV(4), .LZ_BLANK(1), .BLINK_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .sec_ones(sec_ones), .sec_tens(sec_tens),
    .running(running), .seg_n(seg_a), .an_n(an_a), .frame_tick(ft_a)
  );

  sevseg_mux2 #(.REFRESH_DIV(4), .LZ_BLANK(0), .BLINK_FRAMES(2)) dut_nz (
    .clk(clk), .reset(reset), .sec_ones(sec_ones), .sec_tens(sec_tens),
    .running(running), .seg_n(seg_b), .an_n(an_b), .frame_tick(ft_b)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic go(input int k);
    while (edge_n < k) tick();
  endtask

  logic [1:0] start_an  [8] = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
  logic [6:0] start_seg [8] = '{7'h7F, 7'h40, 7'h40, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

  initial begin
    reset = 1'b1; sec_ones = 4'd0; sec_tens = 4'd0; running = 1'b0;
    repeat (3) tick();
    check("rst_seg", 8'(seg_a), 8'h7F);
    check("rst_an", 8'(an_a), 8'h03);
    check("rst_ft", 8'(ft_a), 8'h00);
    check("rst_an_nz", 8'(an_b), 8'h03);

    // Startup frame: dead slot, ones "0", then blanked tens.
    reset = 1'b0; edge_n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("start_an%0d", i + 1), 8'(an_a), 8'(start_an[i]));
      check($sformatf("start_seg%0d", i + 1), 8'(seg_a), 8'(start_seg[i]));
      check($sformatf("start_ft%0d", i + 1), 8'(ft_a), (i == 7) ? 8'h01 : 8'h00);
      if (i == 5) begin
        check("nz_tens_an", 8'(an_b), 8'h01);
        check("nz_tens_seg", 8'(seg_b), 8'h40);
      end
    end

    // Snapshot: mid-frame change stays hidden until the next frame start.
    sec_tens = 4'd4; sec_ones = 4'd7;
    go(10);
    check("snap_hold_an", 8'(an_a), 8'h02);
    check("snap_hold_seg", 8'(seg_a), 8'h40);
    go(15);
    check("snap_ft_lo", 8'(ft_a), 8'h00);
    go(16);
    check("snap_ft_hi", 8'(ft_a), 8'h01);
    go(17);
    sec_ones = 4'd5;
    go(18);
    check("snap_ones_an", 8'(an_a), 8'h02);
    check("snap_ones_seg", 8'(seg_a), 8'h78);
    go(20);
    check("tear_ones_seg", 8'(seg_a), 8'h78);
    go(22);
    check("snap_tens_an", 8'(an_a), 8'h01);
    check("snap_tens_seg", 8'(seg_a), 8'h19);
    go(26);
    check("tear_next_seg", 8'(seg_a), 8'h12);

    // Invalid tens digit shows a dash.
    sec_tens = 4'hB; sec_ones = 4'd9;
    go(34);
    check("inv_ones_seg", 8'(seg_a), 8'h10);
    go(38);
    check("inv_tens_an", 8'(an_a), 8'h01);
    check("inv_tens_seg", 8'(seg_a), 8'h3F);
    check("inv_tens_seg_nz", 8'(seg_b), 8'h3F);

    // Reset with ref_cnt=2 in DIG1.
    reset = 1'b1;
    tick();
    check("mid_rst_an", 8'(an_a), 8'h03);
    check("mid_rst_seg", 8'(seg_a), 8'h7F);
    check("mid_rst_ft", 8'(ft_a), 8'h00);
    reset = 1'b0; edge_n = 0;
    tick();
    check("mid_r1_an", 8'(an_a), 8'h03);
    go(2);
    check("mid_r2_an", 8'(an_a), 8'h02);
    check("mid_r2_seg", 8'(seg_a), 8'h40);
    go(4);
    check("mid_r4_ft", 8'(ft_a), 8'h00);
    go(6);
    check("mid_r6_an", 8'(an_a), 8'h03);
    check("mid_r6_an_nz", 8'(an_b), 8'h01);
    check("mid_r6_seg_nz", 8'(seg_b), 8'h40);
    go(8);
    check("mid_r8_ft", 8'(ft_a), 8'h01);

    // Paused display 12: blinks 2 frames on / 2 off when enabled, steady otherwise.
    sec_tens = 4'd1; sec_ones = 4'd2; running = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0; edge_n = 0;
    go(10);
    check("blk_f1_an", 8'(an_a), 8'h02);
    check("blk_f1_seg", 8'(seg_a), 8'h24);
    go(18);
    check("blk_f2_an", 8'(an_a), BLINK ? 8'h03 : 8'h02);
    check("blk_f2_seg", 8'(seg_a), BLINK ? 8'h7F : 8'h24);
    go(26);
    check("blk_f3_an", 8'(an_a), BLINK ? 8'h03 : 8'h02);
    go(34);
    check("blk_f4_an", 8'(an_a), 8'h02);
    go(42);
    check("blk_f5_an", 8'(an_a), 8'h02);
    running = 1'b1;
    go(50);
    check("run_f6_an", 8'(an_a), 8'h02);
    check("run_f6_seg", 8'(seg_a), 8'h24);
    go(54);
    check("run_f6_tens_an", 8'(an_a), 8'h01);
    check("run_f6_tens_seg", 8'(seg_a), 8'h79);
    go(58);
    check("run_f7_an", 8'(an_a), 8'h02);
    go(66);
    check("run_f8_an", 8'(an_a), 8'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
